semaforo_rr: RTL

- Parametrised, clocked successor to the 4-approach combinational traffic-light block.
- Serves N approaches. Each approach has a vehicle-presence sensor and a red/yellow/green lamp set.
- Grants right-of-way to one approach at a time, in round-robin order among requesting approaches.
- Enforces minimum green, maximum green, yellow and all-red clearance times, all counted in clock cycles.
- Sits between the sensor synchronisers and the lamp drivers.

---
 rtl/semaforo_rr.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/semaforo_rr.sv
// -----------------------------------------------------------------------------
// semaforo_rr -- round-robin traffic-light controller for N approaches.
//
// One approach holds right-of-way at a time. Each grant runs
// ALL_RED -> GREEN -> YELLOW -> ALL_RED. Green lasts at least GREEN_MIN
// cycles. It ends early (gap-out) when its own sensor drops while another
// approach waits, or at GREEN_MAX (max-out) while another approach waits.
// Simultaneous requests are arbitrated only when leaving ALL_RED.
//
// Ports
//   clk     in   1         rising-edge clock
//   rst     in   1         synchronous active-high reset
//   req     in   N         vehicle present per approach (already synchronised)
//   green   out  N         green lamp per approach (registered)
//   yellow  out  N         yellow lamp per approach (registered)
//   red     out  N         red lamp per approach (registered)
//   active  out  AW        approach currently or most recently granted
//   phase   out  2         0 = ALL_RED, 1 = GREEN, 2 = YELLOW
// -----------------------------------------------------------------------------
module semaforo_rr #(
  parameter int N         = 4,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int CW        = 8,
  localparam int AW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  green,
  output logic [N-1:0]  yellow,
  output logic [N-1:0]  red,
  output logic [AW-1:0] active,
  output logic [1:0]    phase
);

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } state_t;

  // Last timer value of each state; the timer saturates there.
  localparam logic [CW-1:0] L_AR_LAST   = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] L_GMIN_LAST = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] L_GMAX_LAST = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] L_Y_LAST    = CW'(YELLOW_T - 1);

  state_t        r_state;
  logic [CW-1:0] r_timer;
  logic [AW-1:0] r_active;
  logic [N-1:0]  r_green;
  logic [N-1:0]  r_yellow;
  logic [N-1:0]  r_red;

  state_t        w_next_state;
  logic [AW-1:0] w_next_active;
  logic [CW-1:0] w_next_timer;
  logic [CW-1:0] w_timer_lim;
  logic [N-1:0]  w_act_onehot;
  logic [N-1:0]  w_next_onehot;
  logic          w_other;
  logic          w_found;
  logic [AW-1:0] w_cand;
  logic [AW-1:0] w_grant_idx;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_next_state  = r_state;
    w_next_active = r_active;
    w_timer_lim   = L_AR_LAST;
    w_act_onehot  = {{(N-1){1'b0}}, 1'b1} << r_active;
    w_other       = |(req & ~w_act_onehot);

    // Rotating priority: search active+1, active+2, ... and active itself last.
    w_found     = 1'b0;
    w_grant_idx = r_active;
    w_cand      = r_active;
    for (int k = 1; k <= N; k++) begin
      w_cand = AW'((int'(r_active) + k) % N);
      if (!w_found && req[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand;
      end
    end

    case (r_state)
      ST_ALL_RED: begin
        w_timer_lim = L_AR_LAST;
        if (r_timer == L_AR_LAST && w_found) begin
          w_next_state  = ST_GREEN;
          w_next_active = w_grant_idx;
        end
      end
      ST_GREEN: begin
        w_timer_lim = L_GMAX_LAST;
        // Only yield when someone else is waiting; otherwise rest on green.
        if (w_other && ((r_timer >= L_GMIN_LAST && !req[r_active]) ||
                        r_timer >= L_GMAX_LAST)) begin
          w_next_state = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        w_timer_lim = L_Y_LAST;
        if (r_timer == L_Y_LAST) w_next_state = ST_ALL_RED;
      end
      default: w_next_state = ST_ALL_RED;
    endcase

    if (w_next_state != r_state) w_next_timer = '0;
    else if (r_timer < w_timer_lim) w_next_timer = r_timer + CW'(1);
    else w_next_timer = r_timer;

    w_next_onehot = {{(N-1){1'b0}}, 1'b1} << w_next_active;
  end

  // Lamps are registered from the next state so they match what the state
  // registers hold; nothing from req reaches the lamps without a flop.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_ALL_RED;
      r_timer  <= '0;
      r_active <= AW'(N - 1);
      r_green  <= '0;
      r_yellow <= '0;
      r_red    <= '1;
    end else begin
      r_state  <= w_next_state;
      r_timer  <= w_next_timer;
      r_active <= w_next_active;
      r_green  <= (w_next_state == ST_GREEN)  ? w_next_onehot : '0;
      r_yellow <= (w_next_state == ST_YELLOW) ? w_next_onehot : '0;
      r_red    <= (w_next_state == ST_ALL_RED) ? '1 : ~w_next_onehot;
    end
  end

  assign green  = r_green;
  assign yellow = r_yellow;
  assign red    = r_red;
  assign active = r_active;
  assign phase  = r_state;

endmodule
